life_ctrl: RTL and testbench
============================

LIFE_CTRL -- requirements
Module: life_ctrl

Interface
REQ-001 Parameter: CNT_W, 24, width of the generation-period counter and period input.
REQ-002 clk  input  1  single system clock; all logic on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 run  input  1  level; 1 = free-running generations, 0 = paused.
REQ-005 single_step  input  1  one-cycle pulse; request exactly one generation while paused.
REQ-006 load_req  input  1  one-cycle pulse; request write of load_val into the array.
REQ-007 load_val  input  16  pattern to load; bit 4*row+col.
REQ-008 period  input  CNT_W  clock cycles between step pulses in RUN.
REQ-009 halt_on_stable  input  1  1 = stop running when a generation produces no change.
REQ-010 alive  input  16  current array state from the life array.
REQ-011 alive_prev  input  16  previous-generation state from the life array.
REQ-012 val  output  16  pattern driven to the array write port.
REQ-013 write_enb  output  1  array write strobe.
REQ-014 step  output  1  array advance strobe; one generation per cycle high.
REQ-015 load_ack  output  1  one-cycle pulse when a load completes.
REQ-016 stable  output  1  last generation produced alive == alive_prev.
REQ-017 gen_count  output  16  generations since last load.
REQ-018 state  output  2  current FSM state encoding.

Function
REQ-019 FSM states SHALL be IDLE, LOAD, RUN, HALT.
REQ-020 IDLE: load_req -> LOAD; else run=1 -> RUN; else single_step -> one step pulse, remain IDLE.
REQ-021 Priority on simultaneous requests in any state SHALL be load_req > run/single_step.
REQ-022 LOAD: cycle 1 val=captured load_val, write_enb=1; cycle 2 write_enb=0, load_ack=1, gen_count=0, stable=0; then IDLE.
REQ-023 val SHALL hold the last captured load_val outside LOAD; write_enb SHALL be high exactly one cycle per load.
REQ-024 RUN: timer counts up each cycle; step=1 for exactly one cycle when timer reaches period-1, timer then restarts at 0.
REQ-025 period values 0, 1 and 2 SHALL all produce a step every 2 cycles (minimum spacing, one check cycle between steps).
REQ-026 The cycle after each step, alive == alive_prev SHALL be sampled: result drives stable; if 1 and halt_on_stable=1 -> HALT.
REQ-027 RUN with run=0 -> IDLE, timer cleared; a step already asserted this cycle still completes.
REQ-028 HALT: step SHALL remain 0; run=0 -> IDLE; load_req -> LOAD; stable held.
REQ-029 Timer SHALL clear on entry to RUN, so the first step occurs period cycles after entry (min 2).
REQ-030 gen_count SHALL increment on every step pulse and saturate at 16'hFFFF.
REQ-031 single_step in RUN or HALT SHALL be ignored; single_step in IDLE also triggers the stable check.

Reset
REQ-032 reset SHALL force state=IDLE, val=0, write_enb=0, step=0, load_ack=0, stable=0, gen_count=0, timer=0, from the next edge, overriding any operation in progress, including mid-LOAD and mid-step.

Structure
REQ-033 Package life_pkg SHALL hold the state typedef (IDLE=0, LOAD=1, RUN=2, HALT=3) and the 16-bit array-width constant.
REQ-034 Period counter SHALL be sub-module life_rate_timer (inputs clk, reset, clear, enable, period; output tick).

Verification
REQ-035 load_req with load_val=16'h0070 -> write_enb=1 with val=16'h0070 for one cycle, load_ack next cycle, alive=16'h0070.
REQ-036 After blinker load, run=1, period=4 -> step every 4 cycles, alive alternates 16'h0222/16'h0070, gen_count=1,2,3..., stable=0.
REQ-037 Load block 16'h0660, halt_on_stable=1, run=1 -> one step, stable=1, state=HALT, no further step while run held.
REQ-038 IDLE, single_step pulse -> exactly one step cycle, gen_count +1; period=0 in RUN -> steps every 2 cycles.
REQ-039 load_req and single_step same cycle in IDLE -> LOAD, no step; load_req mid-RUN -> LOAD, gen_count=0.
REQ-040 reset asserted during RUN and during LOAD cycle 1 -> all outputs at reset values next cycle, no write_enb/step.

Source files
------------

// File: rtl/life_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : life_pkg
//  Description : Shared types and constants for the Game-of-Life controller.
//                Holds the controller state encoding and the cell-array width.
//  Revision    : 1.0 - initial release
// ============================================================================
package life_pkg;

   // Number of cells in the 4x4 array; cell (row, col) lives at bit 4*row+col.
   localparam int c_arr_w = 16;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_RUN  = 2'd2,
      ST_HALT = 2'd3
   } state_t;

endpackage
`default_nettype wire

// File: rtl/life_rate_timer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : life_rate_timer
//  Description : Generation-period counter. Counts while enabled and raises
//                tick for one cycle on the last count of each period, then
//                restarts from zero. Periods below 2 are stretched to 2.
//  Ports       : clk, reset  - clock / synchronous active-high reset
//                clear       - force the count back to zero
//                enable      - count this cycle
//                period      - cycles between ticks
//                tick        - high on the final cycle of each period
//  Revision    : 1.0 - initial release
// ============================================================================
module life_rate_timer #(
   parameter int CNT_W = 24
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic             enable,
   input  logic [CNT_W-1:0] period,
   output logic             tick
);

   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_last;

   // A step must always be followed by at least one check cycle, so the
   // shortest usable period is 2 cycles.
   assign w_last = (period < CNT_W'(2)) ? CNT_W'(1) : (period - CNT_W'(1));

   // ">=" keeps the counter from running away if period shrinks mid-count.
   assign tick = enable && (r_cnt >= w_last);

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         r_cnt <= '0;
      end else if (enable) begin
         r_cnt <= tick ? '0 : (r_cnt + CNT_W'(1));
      end
   end

endmodule
`default_nettype wire

// File: rtl/life_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : life_ctrl
//  Description : Controller for a 4x4 Game-of-Life array. Loads patterns,
//                issues generation step strobes (free-running or single-step),
//                detects stable generations and optionally halts on them.
//  Ports       : clk, reset        - clock / synchronous active-high reset
//                run               - 1 = free-running generations
//                single_step       - one-generation request while idle
//                load_req/load_val - pattern load request and data
//                period            - cycles between steps while running
//                halt_on_stable    - stop running on an unchanged generation
//                alive/alive_prev  - current / previous array state
//                val, write_enb    - array write port
//                step              - array advance strobe
//                load_ack          - load completion pulse
//                stable            - last checked generation was unchanged
//                gen_count         - generations since the last load
//                state             - controller state encoding
//  Revision    : 1.0 - initial release
// ============================================================================
module life_ctrl
   import life_pkg::*;
#(
   parameter int CNT_W = 24
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               run,
   input  logic               single_step,
   input  logic               load_req,
   input  logic [c_arr_w-1:0] load_val,
   input  logic [CNT_W-1:0]   period,
   input  logic               halt_on_stable,
   input  logic [c_arr_w-1:0] alive,
   input  logic [c_arr_w-1:0] alive_prev,
   output logic [c_arr_w-1:0] val,
   output logic               write_enb,
   output logic               step,
   output logic               load_ack,
   output logic               stable,
   output logic [15:0]        gen_count,
   output logic [1:0]         state
);

   state_t             r_state;
   state_t             w_state_nxt;
   logic               r_ld_ph;       // 0 = write cycle, 1 = acknowledge cycle
   logic               w_ld_ph_nxt;
   logic               r_ss_step;     // single-step strobe issued from IDLE
   logic               r_chk;         // cycle after a step: compare generations
   logic               r_stable;
   logic [15:0]        r_gen;
   logic [c_arr_w-1:0] r_val;
   logic               w_tick;
   logic               w_step;
   logic               w_we;
   logic               w_ack;
   logic               w_same;
   logic               w_tmr_en;
   logic               w_tmr_clr;

   assign w_same    = (alive == alive_prev);
   assign w_tmr_en  = (r_state == ST_RUN);
   // Clearing on the exit edge as well guarantees a fresh count on re-entry.
   assign w_tmr_clr = (r_state != ST_RUN) || (w_state_nxt != ST_RUN);

   life_rate_timer #(
      .CNT_W (CNT_W)
   ) u_timer (
      .clk    (clk),
      .reset  (reset),
      .clear  (w_tmr_clr),
      .enable (w_tmr_en),
      .period (period),
      .tick   (w_tick)
   );

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ST_IDLE;
         r_ld_ph <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_ld_ph <= w_ld_ph_nxt;
      end
   end

   // Next-state logic; a load request pre-empts everything, in any state.
   always_comb begin
      w_state_nxt = r_state;
      w_ld_ph_nxt = 1'b0;
      if (load_req) begin
         w_state_nxt = ST_LOAD;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (run) w_state_nxt = ST_RUN;
            end
            ST_LOAD: begin
               if (!r_ld_ph) w_ld_ph_nxt = 1'b1;
               else          w_state_nxt = ST_IDLE;
            end
            ST_RUN: begin
               if (!run)                                  w_state_nxt = ST_IDLE;
               else if (r_chk && w_same && halt_on_stable) w_state_nxt = ST_HALT;
            end
            ST_HALT: begin
               if (!run) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
         endcase
      end
   end

   // Output logic
   always_comb begin
      w_we      = (r_state == ST_LOAD) && !r_ld_ph;
      w_ack     = (r_state == ST_LOAD) &&  r_ld_ph;
      w_step    = w_tick || r_ss_step;
      write_enb = w_we;
      load_ack  = w_ack;
      step      = w_step;
      val       = r_val;
      stable    = r_stable;
      gen_count = r_gen;
      state     = r_state;
   end

   // Datapath registers
   always_ff @(posedge clk) begin
      if (reset) begin
         r_val     <= '0;
         r_ss_step <= 1'b0;
         r_chk     <= 1'b0;
         r_stable  <= 1'b0;
         r_gen     <= '0;
      end else begin
         if (load_req) r_val <= load_val;
         // run and load both outrank a single-step request in IDLE.
         r_ss_step <= (r_state == ST_IDLE) && single_step && !load_req && !run;
         r_chk     <= w_step;
         if (w_we) begin
            // Write cycle of a load: the acknowledge cycle shows the cleared values.
            r_stable <= 1'b0;
            r_gen    <= '0;
         end else begin
            if (r_chk) r_stable <= w_same;
            if (w_step && (r_gen != 16'hFFFF)) r_gen <= r_gen + 16'd1;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_life_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_life_ctrl
//  Description : Self-checking bench for life_ctrl. A 4x4 life array model
//                responds to the controller; a reference model computes the
//                expected outputs every cycle, and directed sequences pin
//                literal values.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_life_ctrl;

   localparam int CNT_W = 24;

   logic             clk            = 1'b0;
   logic             reset          = 1'b1;
   logic             run            = 1'b0;
   logic             single_step    = 1'b0;
   logic             load_req       = 1'b0;
   logic             halt_on_stable = 1'b0;
   logic [15:0]      load_val       = '0;
   logic [CNT_W-1:0] period         = 24'd4;
   logic [15:0]      alive          = '0;
   logic [15:0]      alive_prev     = '0;
   logic [15:0]      val;
   logic [15:0]      gen_count;
   logic             write_enb, step, load_ack, stable;
   logic [1:0]       state;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   life_ctrl #(.CNT_W(CNT_W)) dut (
      .clk            (clk),
      .reset          (reset),
      .run            (run),
      .single_step    (single_step),
      .load_req       (load_req),
      .load_val       (load_val),
      .period         (period),
      .halt_on_stable (halt_on_stable),
      .alive          (alive),
      .alive_prev     (alive_prev),
      .val            (val),
      .write_enb      (write_enb),
      .step           (step),
      .load_ack       (load_ack),
      .stable         (stable),
      .gen_count      (gen_count),
      .state          (state)
   );

   // ---------------- life array (bounded 4x4 grid) ----------------
   function automatic logic [15:0] life_next(input logic [15:0] a);
      logic [15:0] n;
      n = '0;
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 4; c++) begin
            int cnt;
            cnt = 0;
            for (int dr = -1; dr <= 1; dr++) begin
               for (int dc = -1; dc <= 1; dc++) begin
                  int rr, cc;
                  rr = r + dr;
                  cc = c + dc;
                  if (!(dr == 0 && dc == 0) && rr >= 0 && rr < 4 && cc >= 0 && cc < 4)
                     if (a[rr*4+cc]) cnt++;
               end
            end
            if (cnt == 3 || (cnt == 2 && a[r*4+c])) n[r*4+c] = 1'b1;
         end
      end
      return n;
   endfunction

   always @(posedge clk) begin
      if (write_enb) begin
         alive      <= val;
         alive_prev <= val;
      end else if (step) begin
         alive_prev <= alive;
         alive      <= life_next(alive);
      end
   end

   // ---------------- reference model ----------------
   // mode: 0 idle, 1 load, 2 run, 3 halt. Steps in run come from the number
   // of cycles spent in run (m_age) modulo the effective period.
   int          m_mode  = 0;
   bit          m_ph    = 0;
   bit          m_ss    = 0;
   bit          m_chk   = 0;
   bit          m_stab  = 0;
   bit          m_valid = 0;
   int          m_age   = 0;
   int          m_gen   = 0;
   logic [15:0] m_val   = '0;

   function automatic bit exp_step();
      int e;
      e = (period < 2) ? 2 : int'(period);
      return (m_mode == 2 && ((m_age + 1) % e) == 0) || m_ss;
   endfunction

   always @(posedge clk) begin : p_model
      bit cur_step, same, nph;
      int nmode;
      cur_step = exp_step();
      same     = (alive == alive_prev);
      if (reset) begin
         m_mode = 0; m_ph = 0; m_ss = 0; m_chk = 0; m_stab = 0;
         m_age = 0; m_gen = 0; m_val = '0; m_valid = 1;
      end else begin
         nph   = 0;
         nmode = m_mode;
         if (load_req) nmode = 1;
         else if (m_mode == 0) begin
            if (run) nmode = 2;
         end else if (m_mode == 1) begin
            if (!m_ph) nph = 1; else nmode = 0;
         end else if (m_mode == 2) begin
            if (!run) nmode = 0;
            else if (m_chk && same && halt_on_stable) nmode = 3;
         end else begin
            if (!run) nmode = 0;
         end
         if (m_mode == 1 && !m_ph) begin
            m_stab = 0;
            m_gen  = 0;
         end else begin
            if (m_chk) m_stab = same;
            if (cur_step && m_gen < 65535) m_gen++;
         end
         m_ss  = (m_mode == 0) && !load_req && !run && single_step;
         m_chk = cur_step;
         if (load_req) m_val = load_val;
         m_age  = (m_mode == 2 && nmode == 2) ? m_age + 1 : 0;
         m_mode = nmode;
         m_ph   = nph;
      end
   end

   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (m_valid) begin
         check("cmp_state", state, m_mode);
         check("cmp_write_enb", write_enb, (m_mode == 1 && !m_ph));
         check("cmp_load_ack", load_ack, (m_mode == 1 && m_ph));
         check("cmp_step", step, exp_step());
         check("cmp_val", val, m_val);
         check("cmp_stable", stable, m_stab);
         check("cmp_gen_count", gen_count, m_gen);
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_step(input int limit, output int n);
      n = 0;
      while (step !== 1'b1 && n < limit) begin
         tick();
         n++;
      end
   endtask

   initial begin
      int n, s, len;

      // reset state
      reset = 1'b1;
      repeat (3) tick();
      check("rst_state", state, 0);
      check("rst_gen", gen_count, 0);
      check("rst_val", val, 0);
      check("rst_strobes", {write_enb, step, load_ack, stable}, 0);
      reset = 1'b0;

      // blinker load
      load_val = 16'h0070; load_req = 1'b1;
      tick();
      load_req = 1'b0;
      check("ld_we", write_enb, 1);
      check("ld_val", val, 16'h0070);
      check("ld_state", state, 1);
      tick();
      check("ld_we_off", write_enb, 0);
      check("ld_ack", load_ack, 1);
      check("ld_gen", gen_count, 0);
      check("ld_alive", alive, 16'h0070);
      tick();
      check("ld_idle", state, 0);
      check("ld_ack_pulse", load_ack, 0);

      // blinker running, period 4
      period = 24'd4; halt_on_stable = 1'b0; run = 1'b1;
      tick();
      check("blk_run", state, 2);
      for (int g = 1; g <= 4; g++) begin
         wait_step(8, n);
         check("blk_gap", n, 3);
         tick();
         check("blk_step_off", step, 0);
         check("blk_gen", gen_count, g);
         check("blk_alive", alive, (g % 2) ? 16'h0222 : 16'h0070);
         check("blk_stable", stable, 0);
      end
      run = 1'b0;
      tick(); tick();
      check("blk_stop", state, 0);

      // block pattern halts on stability
      load_val = 16'h0660; load_req = 1'b1;
      tick();
      load_req = 1'b0;
      tick(); tick();
      halt_on_stable = 1'b1; run = 1'b1;
      tick();
      wait_step(8, n);
      check("hlt_gap", n, 3);
      tick();
      check("hlt_gen", gen_count, 1);
      tick();
      check("hlt_stable", stable, 1);
      check("hlt_state", state, 3);
      s = 0;
      repeat (10) begin
         tick();
         if (step) s++;
      end
      check("hlt_nostep", s, 0);
      check("hlt_hold", state, 3);
      run = 1'b0;
      tick();
      check("hlt_exit", state, 0);
      check("hlt_stable_held", stable, 1);

      // single step from idle
      single_step = 1'b1;
      tick();
      single_step = 1'b0;
      check("ss_step", step, 1);
      check("ss_state", state, 0);
      tick();
      check("ss_step_off", step, 0);
      check("ss_gen", gen_count, 2);
      tick();
      check("ss_stay_idle", state, 0);

      // period 0 gives one step every 2 cycles
      period = 24'd0; halt_on_stable = 1'b0; run = 1'b1;
      tick();
      for (int k = 0; k < 4; k++) begin
         wait_step(8, n);
         check("p0_gap", n, 1);
         tick();
      end
      check("p0_gen", gen_count, 6);

      // load and single step together in idle
      run = 1'b0;
      tick(); tick();
      check("ls_idle", state, 0);
      load_val = 16'h8001; load_req = 1'b1; single_step = 1'b1;
      tick();
      load_req = 1'b0; single_step = 1'b0;
      check("ls_state", state, 1);
      check("ls_nostep", step, 0);
      tick();
      check("ls_nostep2", step, 0);
      check("ls_ack", load_ack, 1);
      tick();

      // load in the middle of running
      period = 24'd3; run = 1'b1;
      tick();
      wait_step(8, n);
      check("mr_gap", n, 2);
      tick();
      check("mr_gen1", gen_count, 1);
      load_val = 16'h0070; load_req = 1'b1;
      tick();
      load_req = 1'b0;
      check("mr_state", state, 1);
      tick();
      check("mr_gen0", gen_count, 0);
      check("mr_ack", load_ack, 1);

      // reset while running
      repeat (3) tick();
      reset = 1'b1;
      tick();
      check("rr_state", state, 0);
      check("rr_val", val, 0);
      check("rr_gen", gen_count, 0);
      check("rr_strobes", {write_enb, step, load_ack, stable}, 0);

      // reset during load write cycle
      reset = 1'b0; run = 1'b0;
      load_val = 16'h0660; load_req = 1'b1;
      tick();
      load_req = 1'b0;
      check("rl_we", write_enb, 1);
      reset = 1'b1;
      tick();
      check("rl_we_off", write_enb, 0);
      check("rl_state", state, 0);
      check("rl_val", val, 0);
      reset = 1'b0;
      tick();
      check("rl_noack", load_ack, 0);
      check("rl_we_none", write_enb, 0);

      // randomized segments; period only changes once out of RUN
      for (int seg = 0; seg < 30; seg++) begin
         run = 1'b0; single_step = 1'b0; load_req = 1'b0; reset = 1'b0;
         repeat (3) tick();
         period         = CNT_W'($urandom_range(0, 6));
         halt_on_stable = 1'($urandom_range(0, 1));
         len            = int'($urandom_range(20, 80));
         for (int i = 0; i < len; i++) begin
            run         = ($urandom_range(0, 9) != 0);
            load_req    = ($urandom_range(0, 19) == 0);
            single_step = ($urandom_range(0, 5) == 0);
            reset       = ($urandom_range(0, 149) == 0);
            case ($urandom_range(0, 3))
               0:       load_val = 16'h0070;
               1:       load_val = 16'h0660;
               2:       load_val = 16'h0222;
               default: load_val = 16'($urandom);
            endcase
            tick();
         end
      end
      run = 1'b0; single_step = 1'b0; load_req = 1'b0; reset = 1'b0;
      repeat (4) tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
